midi_serial_rx: RTL and testbench

Receives the serial MIDI stream (31250 baud, 8N1, idle high) from the physical MIDI-in pin and decodes Note On / Note Off messages. Emits note-start events as midi_data/midi_valid for midi_player, which sits directly downstream, plus velocity and note-off strobes. It is built from a byte-level UART receiver followed by a running-status message parser.

---
 rtl/midi_pkg.sv | 23 ++
 rtl/midi_serial_rx_uart.sv | 116 +++++++++++
 rtl/midi_serial_rx.sv | 120 ++++++++++++
 tb/tb_midi_serial_rx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared constants and state types for the MIDI receive path.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [7:0] SYS_MIN  = 8'hF0;
  localparam logic [7:0] RT_MIN   = 8'hF8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  typedef enum logic [1:0] {
    P_NO_STATUS,
    P_WAIT_NOTE,
    P_WAIT_VEL
  } parse_state_e;

endpackage

// File: rtl/midi_serial_rx_uart.sv
// 8N1 byte receiver: 2-flop synchroniser plus mid-bit sampling FSM.
//  state        | meaning
//  RX_IDLE      | line high, waiting for a start edge
//  RX_START     | waiting half a bit to confirm the start bit
//  RX_DATA      | sampling 8 data bits, LSB first
//  RX_STOP      | sampling the stop bit
//  RX_WAIT_HIGH | framing error seen, waiting for line to return high
module midi_uart_byte_rx
  import midi_pkg::*;
#(
  parameter int unsigned BIT_CLKS = 3200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       framing_err_o
);

  localparam int unsigned CW = $clog2(BIT_CLKS);
  // The IDLE cycle that spots the low sample already counts toward the half bit.
  localparam logic [CW-1:0] HALF_LOAD = CW'(BIT_CLKS / 2 - 2);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(BIT_CLKS - 1);

  logic [1:0]    sync_q;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_valid_q, byte_valid_d;
  logic          ferr_q, ferr_d;
  logic          rx_s;
  logic          tick;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= 2'b11;
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      ferr_q       <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], rx_i};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      ferr_q       <= ferr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    ferr_d       = 1'b0;
    tick         = (cnt_q == '0);
    case (state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          state_d = RX_START;
          cnt_d   = HALF_LOAD;
        end
      end
      RX_START: begin
        if (!tick) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rx_s) begin
          state_d = RX_IDLE;
        end else begin
          state_d = RX_DATA;
          cnt_d   = BIT_LOAD;
          bit_d   = '0;
        end
      end
      RX_DATA: begin
        if (!tick) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = BIT_LOAD;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (!tick) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rx_s) begin
          byte_valid_d = 1'b1;
          state_d      = RX_IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_s) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_o        = shift_q;
  assign byte_valid_o  = byte_valid_q;
  assign framing_err_o = ferr_q;

endmodule

// File: rtl/midi_serial_rx.sv
// MIDI-in front end: UART byte receiver feeding a running-status Note On/Off parser.
//  state       | meaning
//  P_NO_STATUS | no accepted running status, data bytes ignored
//  P_WAIT_NOTE | running status held, next data byte is the note
//  P_WAIT_VEL  | note stored, next data byte is the velocity
module midi_serial_rx
  import midi_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100000000,
  parameter int unsigned BAUD    = 31250,
  parameter int unsigned CHANNEL = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       midi_rx,
  output logic [7:0] midi_data,
  output logic       midi_valid,
  output logic [6:0] midi_velocity,
  output logic       note_off_valid,
  output logic       framing_err
);

  localparam int unsigned BIT_CLKS = CLK_HZ / BAUD;
  localparam bit          OMNI     = (CHANNEL > 15);
  localparam logic [3:0]  CH_SEL   = CHANNEL[3:0];

  logic [7:0]   rx_byte;
  logic         rx_valid;
  parse_state_e pstate_q, pstate_d;
  logic         rs_on_q, rs_on_d;
  logic [6:0]   note_q, note_d;
  logic [7:0]   data_q, data_d;
  logic [6:0]   vel_q, vel_d;
  logic         mv_q, mv_d;
  logic         nov_q, nov_d;
  logic         is_note_status;
  logic         ch_ok;

  midi_uart_byte_rx #(.BIT_CLKS(BIT_CLKS)) u_uart (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_i         (midi_rx),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .framing_err_o(framing_err)
  );

  assign is_note_status = (rx_byte[7:4] == NOTE_ON) || (rx_byte[7:4] == NOTE_OFF);
  assign ch_ok          = OMNI || (rx_byte[3:0] == CH_SEL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pstate_q <= P_NO_STATUS;
      rs_on_q  <= 1'b0;
      note_q   <= '0;
      data_q   <= '0;
      vel_q    <= '0;
      mv_q     <= 1'b0;
      nov_q    <= 1'b0;
    end else begin
      pstate_q <= pstate_d;
      rs_on_q  <= rs_on_d;
      note_q   <= note_d;
      data_q   <= data_d;
      vel_q    <= vel_d;
      mv_q     <= mv_d;
      nov_q    <= nov_d;
    end
  end

  always_comb begin
    pstate_d = pstate_q;
    rs_on_d  = rs_on_q;
    note_d   = note_q;
    data_d   = data_q;
    vel_d    = vel_q;
    mv_d     = 1'b0;
    nov_d    = 1'b0;
    if (rx_valid) begin
      if (rx_byte >= RT_MIN) begin
        // realtime bytes may interleave anywhere and must not disturb the message
      end else if (rx_byte >= SYS_MIN) begin
        pstate_d = P_NO_STATUS;
        rs_on_d  = 1'b0;
      end else if (rx_byte[7]) begin
        if (is_note_status && ch_ok) begin
          pstate_d = P_WAIT_NOTE;
          rs_on_d  = (rx_byte[7:4] == NOTE_ON);
        end else begin
          pstate_d = P_NO_STATUS;
          rs_on_d  = 1'b0;
        end
      end else begin
        case (pstate_q)
          P_WAIT_NOTE: begin
            note_d   = rx_byte[6:0];
            pstate_d = P_WAIT_VEL;
          end
          P_WAIT_VEL: begin
            data_d   = {1'b0, note_q};
            pstate_d = P_WAIT_NOTE;
            if (rs_on_q && (rx_byte[6:0] != 7'd0)) begin
              vel_d = rx_byte[6:0];
              mv_d  = 1'b1;
            end else begin
              nov_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign midi_data      = data_q;
  assign midi_velocity  = vel_q;
  assign midi_valid     = mv_q;
  assign note_off_valid = nov_q;

endmodule

// File: tb/tb_midi_serial_rx.sv
// Scoreboard bench: an omni instance and a channel-0 instance share one MIDI line.
module tb_midi_serial_rx;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 31250;
  localparam int B      = CLK_HZ / BAUD;
  localparam int HALF   = B / 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic line = 1'b1;

  logic [7:0] data0, data1;
  logic [6:0] vel0, vel1;
  logic       mv0, mv1, nov0, nov1, fe0, fe1;

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  midi_serial_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .CHANNEL(16)) dut_omni (
    .clk(clk), .rst_n(rst_n), .midi_rx(line),
    .midi_data(data0), .midi_valid(mv0), .midi_velocity(vel0),
    .note_off_valid(nov0), .framing_err(fe0)
  );

  midi_serial_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .CHANNEL(0)) dut_ch0 (
    .clk(clk), .rst_n(rst_n), .midi_rx(line),
    .midi_data(data1), .midi_valid(mv1), .midi_velocity(vel1),
    .note_off_valid(nov1), .framing_err(fe1)
  );

  // kind: 0 note on, 1 note off, 2 framing error
  typedef struct {
    int     kind;
    int     note;
    int     vel;
    longint at;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];

  int checks = 0;
  int passed = 0;

  int filt[2]    = '{16, 0};
  int m_state[2] = '{0, 0};   // 0 no status, 1 expecting note, 2 expecting velocity
  bit m_on[2]    = '{0, 0};
  int m_note[2]  = '{0, 0};
  int m_vel[2]   = '{0, 0};

  task automatic chk(input bit ok, input string name, input longint got, input longint exp);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic push_ev(input int i, input ev_t e);
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Reference: interpret one received byte per instance, MIDI running-status rules.
  task automatic model_byte(input int b, input longint t0);
    for (int i = 0; i < 2; i++) begin
      ev_t e;
      int  kind;
      int  ch;
      kind = b >> 4;
      ch   = b & 15;
      if (b >= 'hF8) continue;
      if (b >= 'h80) begin
        if ((kind == 8 || kind == 9) && (filt[i] == 16 || filt[i] == ch)) begin
          m_state[i] = 1;
          m_on[i]    = (kind == 9);
        end else begin
          m_state[i] = 0;
        end
      end else if (m_state[i] == 1) begin
        m_note[i]  = b;
        m_state[i] = 2;
      end else if (m_state[i] == 2) begin
        e.note = m_note[i];
        e.at   = t0 + 3 + HALF + 9 * B;
        if (m_on[i] && b != 0) begin
          m_vel[i] = b;
          e.kind   = 0;
        end else begin
          e.kind = 1;
        end
        e.vel      = m_vel[i];
        m_state[i] = 1;
        push_ev(i, e);
      end
    end
  endtask

  task automatic wait_bits(input int n);
    repeat (n * B) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int b, input bit stop_ok, input int hold_low);
    longint t0;
    ev_t    e;
    @(posedge clk);
    #1;
    t0 = cyc;
    if (stop_ok) begin
      model_byte(b, t0);
    end else begin
      e.kind = 2; e.note = 0; e.vel = 0;
      e.at   = t0 + 2 + HALF + 9 * B;
      push_ev(0, e);
      push_ev(1, e);
    end
    line = 1'b0;
    wait_bits(1);
    for (int k = 0; k < 8; k++) begin
      line = ((b >> k) & 1) != 0;
      wait_bits(1);
    end
    line = stop_ok;
    wait_bits(1);
    if (!stop_ok) wait_bits(hold_low);
    line = 1'b1;
  endtask

  task automatic send_bytes(input int bs[$]);
    foreach (bs[k]) send_frame(bs[k], 1'b1, 0);
  endtask

  task automatic mon(input int i, input logic mv, input logic nov, input logic fe,
                     input logic [7:0] d, input logic [6:0] v);
    ev_t e;
    bit  empty;
    if (mv || nov) begin
      chk(!(mv && nov), $sformatf("exclusive strobes[%0d]", i), {mv, nov}, 0);
      empty = (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
      if (empty) begin
        chk(1'b0, $sformatf("unexpected note event[%0d]", i), d, -1);
      end else begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        chk(e.kind == (mv ? 0 : 1), $sformatf("event kind[%0d]", i), mv ? 0 : 1, e.kind);
        chk(d == e.note, $sformatf("midi_data[%0d]", i), d, e.note);
        chk(v == e.vel, $sformatf("midi_velocity[%0d]", i), v, e.vel);
        chk(cyc == e.at, $sformatf("event cycle[%0d]", i), cyc, e.at);
      end
    end
    if (fe) begin
      empty = (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
      if (empty) begin
        chk(1'b0, $sformatf("unexpected framing_err[%0d]", i), 1, 0);
      end else begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        chk(e.kind == 2, $sformatf("framing kind[%0d]", i), 2, e.kind);
        chk(cyc == e.at, $sformatf("framing cycle[%0d]", i), cyc, e.at);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, mv0, nov0, fe0, data0, vel0);
      mon(1, mv1, nov1, fe1, data1, vel1);
    end
  end

  task automatic check_zero(input string tag);
    chk(data0 == 0 && data1 == 0, {tag, " midi_data"}, {data0, data1}, 0);
    chk(vel0 == 0 && vel1 == 0, {tag, " midi_velocity"}, {vel0, vel1}, 0);
    chk({mv0, mv1, nov0, nov1, fe0, fe1} == 0, {tag, " strobes"}, {mv0, mv1, nov0, nov1, fe0, fe1}, 0);
  endtask

  initial begin
    int r;
    int b;
    repeat (4) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    wait_bits(1);

    send_bytes('{'h90, 'h3C, 'h64});
    send_bytes('{'h3D, 'h50, 'h3D, 'h00});
    send_bytes('{'h90, 'h3E, 'hF8, 'h40});
    send_bytes('{'h90, 'h3E});
    send_frame('h00, 1'b0, 5);
    wait_bits(2);
    send_bytes('{'h40});
    send_bytes('{'h91, 'h3C, 'h64});

    @(posedge clk);
    #1;
    line = 1'b0;
    repeat (HALF - 10) @(posedge clk);
    #1;
    line = 1'b1;
    wait_bits(2);

    for (int n = 0; n < 50; n++) begin
      r = $urandom_range(0, 99);
      if (r < 20)      b = ($urandom_range(0, 1) ? 'h90 : 'h80) | $urandom_range(0, 2);
      else if (r < 70) b = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 127);
      else if (r < 78) b = $urandom_range('hF8, 'hFF);
      else if (r < 86) b = $urandom_range('hF0, 'hF7);
      else             b = $urandom_range('hA0, 'hEF);
      send_frame(b, 1'b1, 0);
      repeat ($urandom_range(0, 40)) @(posedge clk);
    end

    send_bytes('{'h90, 'h3C, 'h64, 'h45});
    wait_bits(2);
    @(posedge clk);
    #1;
    line = 1'b0;
    wait_bits(3);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async reset");
    chk(q0.size() == 0 && q1.size() == 0, "pending before reset", q0.size() + q1.size(), 0);
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0;
      m_vel[i]   = 0;
    end
    line = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_bits(1);
    send_bytes('{'h90, 'h3C, 'h64});

    wait_bits(3);
    chk(q0.size() == 0, "omni queue drained", q0.size(), 0);
    chk(q1.size() == 0, "ch0 queue drained", q1.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
